// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit that produces HI/LO for
// MULT, MULTU, DIV and DIVU. It resolves one bit per clock under a
// start/busy/done handshake.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous reset, active low
//   start    in   request; sampled only while idle
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//   a, b     in   multiplicand/dividend and multiplier/divisor
//   hi       out  MULT: upper product; DIV: remainder
//   lo       out  MULT: lower product; DIV: quotient
//   busy     out  high whenever the FSM is not idle
//   done     out  one-cycle pulse; hi/lo/div_zero are valid with it
//   div_zero out  divide with b==0; held until the next accepted start
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; operands are latched on acceptance
// PREP   | take operand magnitudes, record result signs, test for b==0
// RUN    | WIDTH shift-add / shift-subtract iterations
// FIX    | apply signs and register hi/lo
// DONE   | done pulse for one cycle, then back to IDLE
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   acc_hi_q;
   logic [WIDTH-1:0]   acc_lo_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_res_q;
   logic               neg_rem_q;

   logic               is_signed;
   logic               is_div;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   mag_a_d;
   logic [WIDTH-1:0]   mag_b_d;
   logic [WIDTH:0]     mul_sum_d;
   logic [WIDTH:0]     div_shift_d;
   logic [WIDTH:0]     div_diff_d;
   logic [2*WIDTH-1:0] prod_neg_d;

   assign is_signed = ~op_q[0];
   assign is_div    = op_q[1];
   assign sign_a    = is_signed & a_q[WIDTH-1];
   assign sign_b    = is_signed & b_q[WIDTH-1];

   // Negating the most-negative value wraps back to itself, which read as
   // unsigned is exactly the required magnitude 2**(WIDTH-1).
   assign mag_a_d = sign_a ? -a_q : a_q;
   assign mag_b_d = sign_b ? -b_q : b_q;

   // Multiply: the multiplier sits in acc_lo and drains out of bit 0 while the
   // product fills in from the top; the carry out of the add shifts into acc_hi.
   assign mul_sum_d = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);

   // Divide: the dividend shifts out of acc_lo into the remainder while quotient
   // bits shift in at the bottom. The remainder stays below the divisor, so the
   // restored value always fits in WIDTH bits.
   assign div_shift_d = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_diff_d  = div_shift_d - {1'b0, b_q};

   assign prod_neg_d = -{acc_hi_q, acc_lo_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q     <= op;
                  a_q      <= a;
                  b_q      <= b;
                  div_zero <= 1'b0;
                  busy     <= 1'b1;
                  state_q  <= S_PREP;
               end
            end
            S_PREP: begin
               neg_res_q <= sign_a ^ sign_b;
               neg_rem_q <= sign_a;
               b_q       <= mag_b_d;
               acc_lo_q  <= mag_a_d;
               acc_hi_q  <= '0;
               cnt_q     <= '0;
               if (is_div && (b_q == '0)) begin
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               if (is_div) begin
                  acc_hi_q <= div_diff_d[WIDTH] ? div_shift_d[WIDTH-1:0] : div_diff_d[WIDTH-1:0];
                  acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~div_diff_d[WIDTH]};
               end else begin
                  acc_hi_q <= mul_sum_d[WIDTH:1];
                  acc_lo_q <= {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_FIX;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            S_FIX: begin
               if (is_div) begin
                  lo <= neg_res_q ? -acc_lo_q : acc_lo_q;
                  hi <= neg_rem_q ? -acc_hi_q : acc_hi_q;
               end else if (neg_res_q) begin
                  {hi, lo} <= prod_neg_d;
               end else begin
                  {hi, lo} <= {acc_hi_q, acc_lo_q};
               end
               done    <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

   localparam int W = 32;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic         clk   = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op    = 2'b00;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         div_zero;

   int   n_checks = 0;
   int   n_err    = 0;
   int   edges;
   int   pulses;
   logic got;

   mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one request and returns the number of rising edges from the
   // sampling edge (counted as 1) up to the edge after which done is seen.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      edges = 0;
      got   = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         start = 1'b0;
         if (done) got = 1'b1;
      end
      chk("done_timeout", {63'd0, got}, 64'd1);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
      reset = 1'b1;

      // 1. MULTU max*max and full latency
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
      chk("multu_lat", 64'(edges), 64'd35);
      chk("multu_busy_done", {62'd0, busy, done}, 64'h3);
      @(negedge clk);
      chk("done_one_cycle", {62'd0, busy, done}, 64'h0);

      // 2. signed multiply, unsigned divide
      run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007);
      chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      run_op(OP_DIVU, 32'd7, 32'd2);
      chk("divu_7_2", {hi, lo}, {32'd1, 32'd3});
      chk("divu_lat", 64'(edges), 64'd35);

      // 3. signed divide, most-negative corner cases
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
      chk("div_neg7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      chk("div_minneg_m1", {hi, lo}, 64'h00000000_80000000);
      run_op(OP_MULT, 32'h80000000, 32'h80000000);
      chk("mult_minneg_sq", {hi, lo}, 64'h40000000_00000000);
      run_op(OP_MULT, 32'd0, 32'd5);
      chk("mult_zero", {hi, lo}, 64'd0);
      chk("mult_zero_lat", 64'(edges), 64'd35);
      run_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
      chk("div_7_neg2", {hi, lo}, 64'h00000001_FFFFFFFD);

      // 4. divide by zero keeps hi/lo, flag holds until next start
      run_op(OP_MULTU, 32'h00010000, 32'h12345678);
      chk("load_hilo", {hi, lo}, 64'h00001234_56780000);
      run_op(OP_DIVU, 32'd5, 32'd0);
      chk("dz_flag", {63'd0, div_zero}, 64'd1);
      chk("dz_lat", 64'(edges), 64'd2);
      chk("dz_hilo", {hi, lo}, 64'h00001234_56780000);
      repeat (3) @(negedge clk);
      chk("dz_held", {63'd0, div_zero}, 64'd1);
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      chk("dz_cleared", {62'd0, busy, div_zero}, 64'h2);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk("dz_next_done", {63'd0, got}, 64'd1);
      chk("dz_next_res", {hi, lo}, 64'd6);

      // 5. start during RUN and during DONE is ignored
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk("ign_done", {63'd0, got}, 64'd1);
      chk("ign_run_res", {hi, lo}, {32'd2, 32'd14});
      start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      chk("ign_done_busy", {62'd0, busy, done}, 64'h0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("ign_no_2nd_done", 64'(pulses), 64'd0);
      chk("ign_res_kept", {hi, lo}, {32'd2, 32'd14});

      // 6. reset during RUN aborts
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      chk("rr_busy_pre", {63'd0, busy}, 64'd1);
      reset = 1'b0;
      #1;
      chk("rr_hilo", {hi, lo}, 64'd0);
      chk("rr_flags", {61'd0, busy, done, div_zero}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("rr_quiet", 64'(pulses), 64'd0);
      run_op(OP_MULT, 32'd6, 32'd7);
      chk("rr_mult_6_7", {hi, lo}, 64'h00000000_0000002A);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
